// File: rtl/cc_window_sequencer.sv
// Character-window sequencer: loads a string into N ring slots, offers one start
// thread per character in load order, and retires slots once no thread uses them.
module cc_window_sequencer #(
    parameter int PC_WIDTH        = 8,
    parameter int CHARACTER_WIDTH = 8,
    parameter int CC_ID_BITS      = 2,
    parameter int START_PC        = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [CHARACTER_WIDTH-1:0]                  in_char,
    input  logic                                        in_valid,
    input  logic                                        in_last,
    output logic                                        in_ready,
    input  logic [(2**CC_ID_BITS)-1:0]                  elaborating_chars,
    output logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  cur_window,
    output logic [(2**CC_ID_BITS)-1:0]                  cur_window_enable,
    output logic [(2**CC_ID_BITS)-1:0]                  cur_window_end_of_s,
    output logic                                        new_char,
    output logic                                        inj_valid,
    output logic [PC_WIDTH+CC_ID_BITS-1:0]              inj_data,
    input  logic                                        inj_ready,
    output logic                                        busy,
    output logic                                        done
);
    localparam int N  = 2**CC_ID_BITS;
    localparam int CW = CHARACTER_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;
    typedef enum logic [1:0] {SL_EMPTY, SL_LOADED, SL_INJECTED, SL_ACTIVE} slot_t;

    fsm_t                  state_q, state_d;
    slot_t                 slot_q [N];
    slot_t                 slot_d [N];
    logic [CW-1:0]         data_q [N];
    logic [CW-1:0]         data_d [N];
    logic [N-1:0]          eos_q, eos_d;
    logic [CC_ID_BITS-1:0] tail_q, tail_d, inj_q, inj_d, head_q, head_d;
    logic                  eos_loaded_q, eos_loaded_d;
    logic                  new_char_q, new_char_d;
    logic                  accept, inj_fire, retire;

    // Handshake outputs depend only on registered state.
    assign in_ready  = (state_q == S_RUN) && (slot_q[tail_q] == SL_EMPTY) && !eos_loaded_q;
    assign inj_valid = (slot_q[inj_q] == SL_LOADED);
    assign inj_data  = {inj_q, PC_WIDTH'(START_PC)};
    assign accept    = in_valid && in_ready;
    assign inj_fire  = inj_valid && inj_ready;
    assign retire    = (state_q == S_RUN) && (slot_q[head_q] == SL_ACTIVE)
                       && !elaborating_chars[head_q];
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign new_char  = new_char_q;

    always_comb begin
        cur_window          = '0;
        cur_window_enable   = '0;
        cur_window_end_of_s = '0;
        for (int i = 0; i < N; i++) begin
            cur_window[i*CW +: CW] = data_q[i];
            cur_window_enable[i]   = (slot_q[i] != SL_EMPTY);
            cur_window_end_of_s[i] = (slot_q[i] != SL_EMPTY) && eos_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        data_d       = data_q;
        eos_d        = eos_q;
        tail_d       = tail_q;
        inj_d        = inj_q;
        head_d       = head_q;
        eos_loaded_d = eos_loaded_q;
        new_char_d   = accept;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    for (int i = 0; i < N; i++) slot_d[i] = SL_EMPTY;
                    eos_d        = '0;
                    tail_d       = '0;
                    inj_d        = '0;
                    head_d       = '0;
                    eos_loaded_d = 1'b0;
                end
            end
            S_RUN: begin
                // One-cycle INJECTED hold lets elaborating_chars catch up with the new thread.
                for (int i = 0; i < N; i++) begin
                    if (slot_q[i] == SL_INJECTED) slot_d[i] = SL_ACTIVE;
                end
                if (accept) begin
                    data_d[tail_q] = in_char;
                    eos_d[tail_q]  = in_last;
                    slot_d[tail_q] = SL_LOADED;
                    tail_d         = tail_q + CC_ID_BITS'(1);
                    if (in_last) eos_loaded_d = 1'b1;
                end
                if (inj_fire) begin
                    slot_d[inj_q] = SL_INJECTED;
                    inj_d         = inj_q + CC_ID_BITS'(1);
                end
                if (retire) begin
                    slot_d[head_q] = SL_EMPTY;
                    eos_d[head_q]  = 1'b0;
                    head_d         = head_q + CC_ID_BITS'(1);
                    if (eos_q[head_q]) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= SL_EMPTY;
                data_q[i] <= '0;
            end
            eos_q        <= '0;
            tail_q       <= '0;
            inj_q        <= '0;
            head_q       <= '0;
            eos_loaded_q <= 1'b0;
            new_char_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            data_q       <= data_d;
            eos_q        <= eos_d;
            tail_q       <= tail_d;
            inj_q        <= inj_d;
            head_q       <= head_d;
            eos_loaded_q <= eos_loaded_d;
            new_char_q   <= new_char_d;
        end
    end
endmodule

// File: tb/tb_cc_window_sequencer.sv
// Bench for cc_window_sequencer: directed scenarios plus random traffic, all checked
// each cycle against a queue-based model of the live characters.
module tb_cc_window_sequencer;
    localparam int PCW = 8;
    localparam int CW  = 8;
    localparam int IDB = 2;
    localparam int N   = 4;
    localparam int SPC = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     in_char = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [N-1:0]      elab = '0;
    logic [N*CW-1:0]   cur_window;
    logic [N-1:0]      win_en;
    logic [N-1:0]      win_eos;
    logic              new_char;
    logic              inj_valid;
    logic [PCW+IDB-1:0] inj_data;
    logic              inj_ready = 1'b0;
    logic              busy;
    logic              done;

    cc_window_sequencer #(
        .PC_WIDTH(PCW), .CHARACTER_WIDTH(CW), .CC_ID_BITS(IDB), .START_PC(SPC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_char(in_char), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .elaborating_chars(elab),
        .cur_window(cur_window), .cur_window_enable(win_en), .cur_window_end_of_s(win_eos),
        .new_char(new_char), .inj_valid(inj_valid), .inj_data(inj_data),
        .inj_ready(inj_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: live characters in load order, each with its slot and injection edge.
    typedef struct {
        int slot;
        bit last;
        int inj_edge;
    } rec_t;

    rec_t          live[$];
    int            m_state = 0;   // 0 idle, 1 run, 2 done
    int            loads = 0;
    bit            eos_ld = 1'b0;
    bit            m_new = 1'b0;
    logic [CW-1:0] last_data [N];
    int            edge_n = 0;
    bit            model_ok = 1'b0;

    initial begin
        int   fi;
        bit   pre_ready;
        rec_t r;
        for (int i = 0; i < N; i++) last_data[i] = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_ok = 1'b1;
                m_state  = 0;
                live.delete();
                loads    = 0;
                eos_ld   = 1'b0;
                m_new    = 1'b0;
                for (int i = 0; i < N; i++) last_data[i] = '0;
            end else begin
                pre_ready = (m_state == 1) && (live.size() < N) && !eos_ld;
                fi = -1;
                for (int k = 0; k < live.size(); k++) begin
                    if (fi < 0 && live[k].inj_edge < 0) fi = k;
                end
                m_new = 1'b0;
                if (m_state != 1) begin
                    if (start) begin
                        m_state = 1;
                        live.delete();
                        loads  = 0;
                        eos_ld = 1'b0;
                    end
                end else begin
                    if (fi >= 0 && inj_ready) begin
                        r = live[fi];
                        r.inj_edge = edge_n;
                        live[fi] = r;
                    end
                    if (live.size() > 0 && live[0].inj_edge >= 0 && edge_n >= live[0].inj_edge + 2
                        && !elab[live[0].slot]) begin
                        if (live[0].last) m_state = 2;
                        void'(live.pop_front());
                    end
                    if (in_valid && pre_ready) begin
                        r.slot = loads % N;
                        r.last = in_last;
                        r.inj_edge = -1;
                        live.push_back(r);
                        last_data[loads % N] = in_char;
                        loads++;
                        if (in_last) eos_ld = 1'b1;
                        m_new = 1'b1;
                    end
                end
            end
            edge_n++;
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [N-1:0]       e_en, e_eos;
        logic [N*CW-1:0]    e_win;
        logic [IDB-1:0]     e_id;
        int                 fi;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                e_en = '0;
                e_eos = '0;
                fi = -1;
                for (int k = 0; k < live.size(); k++) begin
                    e_en[live[k].slot]  = 1'b1;
                    e_eos[live[k].slot] = live[k].last;
                    if (fi < 0 && live[k].inj_edge < 0) fi = k;
                end
                for (int i = 0; i < N; i++) e_win[i*CW +: CW] = last_data[i];
                chk("in_ready", in_ready, (m_state == 1) && (live.size() < N) && !eos_ld);
                chk("inj_valid", inj_valid, fi >= 0);
                if (fi >= 0) begin
                    e_id = IDB'(live[fi].slot);
                    chk("inj_data", inj_data, {e_id, PCW'(SPC)});
                end
                chk("enable", win_en, e_en);
                chk("end_of_s", win_eos, e_eos);
                chk("cur_window", cur_window, e_win);
                chk("new_char", new_char, m_new);
                chk("busy", busy, m_state == 1);
                chk("done", done, m_state == 2);
            end
        end
    end

    int             newc = 0;
    logic [PCW+IDB-1:0] inj_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (new_char === 1'b1) newc++;
            if (inj_valid === 1'b1 && inj_ready) inj_log.push_back(inj_data);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [CW-1:0] c, input bit last);
        bit acc;
        acc = 1'b0;
        in_char  = c;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic wait_done();
        bit d;
        d = 1'b0;
        for (int k = 0; k < 400 && !d; k++) begin
            @(negedge clk);
            d = done;
        end
        @(posedge clk);
        #1;
        chk("wait_done", d, 1'b1);
    endtask

    initial begin
        cyc(3);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_inj_valid", inj_valid, 0);
        chk("rst_enable", win_en, 0);
        chk("rst_window", cur_window, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1);

        // Two-character string.
        inj_ready = 1'b1;
        elab = '0;
        do_start();
        newc = 0;
        inj_log.delete();
        send(8'h61, 1'b0);
        send(8'h62, 1'b1);
        wait_done();
        chk("ab_new_char_count", newc, 2);
        chk("ab_inj_count", inj_log.size(), 2);
        chk("ab_inj0", inj_log[0], 10'h000);
        chk("ab_inj1", inj_log[1], 10'h100);

        // Window full while every thread keeps its slot busy.
        elab = 4'hF;
        do_start();
        for (int i = 0; i < 4; i++) send(CW'(8'h30 + i), 1'b0);
        in_char = 8'h65;
        in_last = 1'b1;
        in_valid = 1'b1;
        cyc(6);
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_enable", win_en, 4'hF);
        chk("full_done", done, 0);
        @(posedge clk);
        #1;
        elab = 4'hE;
        send(8'h65, 1'b1);
        chk("full_slot0_reload", cur_window[7:0], 8'h65);
        elab = '0;
        wait_done();

        // Injection back-pressure.
        do_start();
        inj_ready = 1'b0;
        send(8'h78, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_inj_valid", inj_valid, 1);
            chk("bp_inj_data", inj_data, 10'h000);
            chk("bp_enable", win_en, 4'h1);
            @(posedge clk);
            #1;
        end
        inj_ready = 1'b1;
        send(8'h79, 1'b1);
        wait_done();

        // Six characters wrap the ring.
        inj_log.delete();
        do_start();
        for (int i = 0; i < 6; i++) send(CW'(8'h61 + i), i == 5);
        wait_done();
        chk("wrap_inj_count", inj_log.size(), 6);
        chk("wrap_inj4", inj_log[4], 10'h000);
        chk("wrap_slot0", cur_window[7:0], 8'h65);

        // Thread presence appears one cycle after injection.
        do_start();
        inj_ready = 1'b0;
        send(8'h67, 1'b1);
        inj_ready = 1'b1;
        cyc(1);
        elab = 4'h1;
        cyc(5);
        @(negedge clk);
        chk("guard_enable", win_en, 4'h1);
        chk("guard_done", done, 0);
        @(posedge clk);
        #1;
        elab = '0;
        wait_done();

        // Reset abandons a partly loaded string.
        do_start();
        inj_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(CW'(8'h41 + i), 1'b0);
        rst = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_inj_valid", inj_valid, 0);
        chk("mid_rst_enable", win_en, 0);
        chk("mid_rst_window", cur_window, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        inj_ready = 1'b1;
        do_start();
        send(8'h7A, 1'b1);
        wait_done();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_char   = CW'($urandom);
            in_last   = ($urandom_range(0, 5) == 0);
            inj_ready = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < N; b++) elab[b] = ($urandom_range(0, 2) == 0);
            cyc(1);
        end
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        inj_ready = 1'b0;
        elab = '0;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cc_window_sequencer.md
CC_WINDOW_SEQUENCER -- requirements
Module: cc_window_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter width of injected threads.
REQ-002 SHALL have parameter CHARACTER_WIDTH, default 8, width of one input character.
REQ-003 SHALL have parameter CC_ID_BITS, default 2, giving N=2**CC_ID_BITS window slots.
REQ-004 SHALL have parameter START_PC, default 0, PC assigned to every injected thread.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin a new string.
- in_char  in  CHARACTER_WIDTH  input character.
- in_valid  in  1  in_char valid.
- in_last  in  1  in_char is the last character of the string.
- in_ready  out  1  character accepted when in_valid && in_ready.
- elaborating_chars  in  N  bit i = some thread still uses slot i.
- cur_window  out  N*CHARACTER_WIDTH  slot i at bits [i*CW +: CW].
- cur_window_enable  out  N  slot i holds a live character.
- cur_window_end_of_s  out  N  slot i holds the last character.
- new_char  out  1  one-cycle pulse per loaded character.
- inj_valid  out  1  start thread offered.
- inj_data  out  PC_WIDTH+CC_ID_BITS  {cc_id (upper), START_PC (lower)}.
- inj_ready  in  1  downstream channel accepts.
- busy  out  1  FSM in RUN.
- done  out  1  FSM in DONE.

Function
REQ-006 SHALL run a top FSM IDLE->RUN on start; RUN->DONE on retiring the end-of-string slot; DONE->RUN on start; start in RUN ignored.
REQ-007 SHALL give each slot a state EMPTY, LOADED, INJECTED, ACTIVE, all initially EMPTY.
REQ-008 SHALL keep tail, inject and head pointers of CC_ID_BITS bits, each wrapping N-1->0, all zeroed on entering RUN.
REQ-009 SHALL drive in_ready = RUN && slot[tail]==EMPTY && no end-of-string character loaded yet, combinationally from registered state only.
REQ-010 SHALL on accept write in_char and in_last into slot[tail], set it LOADED, pulse new_char next cycle, increment tail.
REQ-011 SHALL drive inj_valid = slot[inject]==LOADED, with inj_data upper bits = inject and lower bits = START_PC; on handshake set slot INJECTED and increment inject; threads are injected strictly in load order.
REQ-012 SHALL move an INJECTED slot to ACTIVE unconditionally one cycle later, guarding against channel presence latency.
REQ-013 SHALL retire slot[head] when it is ACTIVE and elaborating_chars[head]==0: set EMPTY, clear its end_of_s, increment head; at most one retire per cycle.
REQ-014 SHALL ignore elaborating_chars bits of slots not ACTIVE.
REQ-015 SHALL drive cur_window_enable[i]=1 for every non-EMPTY slot; cur_window_end_of_s[i] = stored in_last of slot i when enabled, else 0; cur_window holds last written data.
REQ-016 SHALL allow load at tail, inject at inject and retire at head in the same cycle; load never targets the retiring slot because it requires registered EMPTY.
REQ-017 SHALL hold in_ready low with all N slots non-EMPTY (full), and keep inj_valid stable until accepted.
REQ-018 SHALL on start from DONE clear all slots to EMPTY.

Reset
REQ-019 SHALL, while rst==0 at a clock edge, force FSM IDLE, all slots EMPTY, pointers 0, and in_ready, new_char, inj_valid, busy, done, cur_window_enable, cur_window_end_of_s all 0; cur_window 0.
REQ-020 SHALL abandon a string mid-operation on reset, with no further injections or done.

Verification
REQ-021 N=4, start, stream "ab" (last on 'b'), inj_ready=1, elaborating_chars=0 -> new_char twice, inj_data 0x000 then 0x100, slots retire in order, done high.
REQ-022 Full: 5 chars, inj_ready=1, elaborating_chars=4'hF -> in_ready low after 4 loads, enable=4'hF, no retire until bit 0 clears.
REQ-023 Back-pressure: inj_ready=0 for 10 cycles after load -> inj_valid and inj_data stable, slot stays LOADED, no retire.
REQ-024 Wrap: 6-char string, elaborating_chars=0 -> 5th char written to slot 0, inj_data cc_id 0 again, done after 6th retire.
REQ-025 Guard: elaborating_chars rises only the cycle after injection -> slot not retired while bit set.
REQ-026 Reset mid-RUN with 3 slots loaded -> next cycle all outputs 0, FSM IDLE; subsequent start works normally.
